// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
// Covers FSM states, RISC-V funct3 size codes, fault causes and the byte-mask helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_MISALIGNED = 3'd1;
    localparam logic [2:0] CAUSE_BUS_ERR    = 3'd2;
    localparam logic [2:0] CAUSE_TIMEOUT    = 3'd3;
    localparam logic [2:0] CAUSE_ILLEGAL    = 3'd4;

    // Byte-lane mask for an access size encoded in funct3[1:0].
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Selects the addressed bytes of a bus read word and sign/zero-extends them to XLEN.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rsp_data,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rsp_data >> {off, 3'b000};
        data    = '0;
        case (funct3)
            F3_B:    data = XLEN'($signed(shifted[7:0]));
            F3_H:    data = XLEN'($signed(shifted[15:0]));
            F3_W:    data = XLEN'($signed(shifted[31:0]));
            F3_D:    data = shifted;
            F3_BU:   data = XLEN'(shifted[7:0]);
            F3_HU:   data = XLEN'(shifted[15:0]);
            F3_WU:   data = XLEN'(shifted[31:0]);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: checks size/alignment, issues one valid/ready bus
// request with lane-aligned data and strobes, and returns an extended result or fault.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    input  logic                op_we,
    input  logic [2:0]          op_funct3,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [XLEN-1:0]     op_wdata,
    output logic                op_ready,
    output logic                done,
    output logic                fault,
    output logic [2:0]          fault_cause,
    output logic [XLEN-1:0]     load_data,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_we,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [XLEN-1:0]     bus_req_wdata,
    output logic [XLEN/8-1:0]   bus_req_strb,
    input  logic                bus_rsp_valid,
    input  logic [XLEN-1:0]     bus_rsp_data,
    input  logic                bus_rsp_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("lsu_mem_stage: XLEN must be 32 or 64");
    end

    lsu_state_e          state;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [CNT_W-1:0]    cnt;

    logic [OFF_W-1:0]    off;
    logic                illegal;
    logic                misaligned;
    logic [STRB_W-1:0]   strb_next;
    logic [XLEN-1:0]     ext_data;

    assign off      = addr_q[OFF_W-1:0];
    assign op_ready = (state == S_IDLE);

    always_comb begin
        illegal = (f3_q == F3_BAD) || (we_q && f3_q[2]) ||
                  ((XLEN == 32) && (f3_q == F3_D || f3_q == F3_WU));
        case (f3_q[1:0])
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = |addr_q[1:0];
            2'b11:   misaligned = |addr_q[2:0];
            default: misaligned = 1'b0;
        endcase
        strb_next = we_q ? (STRB_W'(size_mask(f3_q[1:0])) << off) : {STRB_W{1'b1}};
    end

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .rsp_data (bus_rsp_data),
        .off      (off),
        .funct3   (f3_q),
        .data     (ext_data)
    );

    // A response in the same cycle as the timeout is checked first, so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            we_q          <= 1'b0;
            f3_q          <= 3'b000;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt           <= '0;
            done          <= 1'b0;
            fault         <= 1'b0;
            fault_cause   <= CAUSE_NONE;
            load_data     <= '0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_strb  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        we_q    <= op_we;
                        f3_q    <= op_funct3;
                        addr_q  <= op_addr;
                        wdata_q <= op_wdata;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (illegal) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_MISALIGNED;
                    end else begin
                        state         <= S_REQ;
                        bus_req_valid <= 1'b1;
                        bus_req_we    <= we_q;
                        bus_req_addr  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_req_wdata <= wdata_q << {off, 3'b000};
                        bus_req_strb  <= strb_next;
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_rsp_valid) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        fault       <= bus_rsp_err;
                        fault_cause <= bus_rsp_err ? CAUSE_BUS_ERR : CAUSE_NONE;
                        if (!bus_rsp_err && !we_q) begin
                            load_data <= ext_data;
                        end
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    fault       <= 1'b0;
                    fault_cause <= CAUSE_NONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a 32-bit instance with a short timeout and a
// 64-bit instance, driven through stores, loads, faults, timeout and reset.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        a_op_valid, a_op_we, a_op_ready, a_done, a_fault;
    logic [2:0]  a_op_funct3, a_cause;
    logic [31:0] a_op_addr, a_op_wdata, a_load_data;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_data;
    logic [3:0]  a_req_strb;

    logic        b_op_valid, b_op_we, b_op_ready, b_done, b_fault;
    logic [2:0]  b_op_funct3, b_cause;
    logic [31:0] b_op_addr, b_req_addr;
    logic [63:0] b_op_wdata, b_load_data, b_req_wdata, b_rsp_data;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
    logic [7:0]  b_req_strb;

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .op_valid(a_op_valid), .op_we(a_op_we), .op_funct3(a_op_funct3),
        .op_addr(a_op_addr), .op_wdata(a_op_wdata), .op_ready(a_op_ready),
        .done(a_done), .fault(a_fault), .fault_cause(a_cause), .load_data(a_load_data),
        .bus_req_valid(a_req_valid), .bus_req_ready(a_req_ready), .bus_req_we(a_req_we),
        .bus_req_addr(a_req_addr), .bus_req_wdata(a_req_wdata), .bus_req_strb(a_req_strb),
        .bus_rsp_valid(a_rsp_valid), .bus_rsp_data(a_rsp_data), .bus_rsp_err(a_rsp_err)
    );

    lsu_mem_stage #(.XLEN(64), .ADDR_W(32), .TIMEOUT(0)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .op_valid(b_op_valid), .op_we(b_op_we), .op_funct3(b_op_funct3),
        .op_addr(b_op_addr), .op_wdata(b_op_wdata), .op_ready(b_op_ready),
        .done(b_done), .fault(b_fault), .fault_cause(b_cause), .load_data(b_load_data),
        .bus_req_valid(b_req_valid), .bus_req_ready(b_req_ready), .bus_req_we(b_req_we),
        .bus_req_addr(b_req_addr), .bus_req_wdata(b_req_wdata), .bus_req_strb(b_req_strb),
        .bus_rsp_valid(b_rsp_valid), .bus_rsp_data(b_rsp_data), .bus_rsp_err(b_rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one operation for a single edge; afterwards the DUT sits in CHECK.
    task automatic apply_op32(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
        a_op_valid = 1'b1; a_op_we = we; a_op_funct3 = f3; a_op_addr = addr; a_op_wdata = wdata;
        tick();
        a_op_valid = 1'b0;
    endtask

    task automatic apply_op64(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [63:0] wdata);
        b_op_valid = 1'b1; b_op_we = we; b_op_funct3 = f3; b_op_addr = addr; b_op_wdata = wdata;
        tick();
        b_op_valid = 1'b0;
    endtask

    // Zero-wait operation (ready held high); returns observing the DONE cycle.
    task automatic apply_run32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rsp, input logic err);
        apply_op32(we, f3, addr, 32'h0);
        tick();
        tick();
        a_rsp_valid = 1'b1; a_rsp_data = rsp; a_rsp_err = err;
        tick();
        a_rsp_valid = 1'b0; a_rsp_err = 1'b0;
    endtask

    task automatic apply_run64(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [63:0] rsp);
        apply_op64(we, f3, addr, 64'h0);
        tick();
        tick();
        b_rsp_valid = 1'b1; b_rsp_data = rsp;
        tick();
        b_rsp_valid = 1'b0;
    endtask

    initial begin
        a_op_valid = 0; a_op_we = 0; a_op_funct3 = 0; a_op_addr = 0; a_op_wdata = 0;
        a_req_ready = 0; a_rsp_valid = 0; a_rsp_data = 0; a_rsp_err = 0;
        b_op_valid = 0; b_op_we = 0; b_op_funct3 = 0; b_op_addr = 0; b_op_wdata = 0;
        b_req_ready = 0; b_rsp_valid = 0; b_rsp_data = 0; b_rsp_err = 0;

        repeat (2) tick();
        check_output("rst_op_ready", 64'(a_op_ready), 64'h1);
        check_output("rst_done", 64'(a_done), 64'h0);
        check_output("rst_fault", 64'(a_fault), 64'h0);
        check_output("rst_cause", 64'(a_cause), 64'h0);
        check_output("rst_load_data", 64'(a_load_data), 64'h0);
        check_output("rst_req_valid", 64'(a_req_valid), 64'h0);
        check_output("rst_req_we", 64'(a_req_we), 64'h0);
        check_output("rst_req_addr", 64'(a_req_addr), 64'h0);
        check_output("rst_req_wdata", 64'(a_req_wdata), 64'h0);
        check_output("rst_req_strb", 64'(a_req_strb), 64'h0);
        check_output("rst64_load_data", b_load_data, 64'h0);
        rst_n = 1'b1;
        tick();

        // SB 0x1003 with the bus holding off ready for three cycles
        apply_op32(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        check_output("sb_check_no_req", 64'(a_req_valid), 64'h0);
        check_output("sb_busy", 64'(a_op_ready), 64'h0);
        tick();
        check_output("sb_req_valid", 64'(a_req_valid), 64'h1);
        check_output("sb_req_we", 64'(a_req_we), 64'h1);
        check_output("sb_req_addr", 64'(a_req_addr), 64'h1000);
        check_output("sb_req_wdata", 64'(a_req_wdata), 64'hAB00_0000);
        check_output("sb_req_strb", 64'(a_req_strb), 64'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("sb_hold_valid", 64'(a_req_valid), 64'h1);
            check_output("sb_hold_wdata", 64'(a_req_wdata), 64'hAB00_0000);
            check_output("sb_hold_strb", 64'(a_req_strb), 64'h8);
        end
        a_req_ready = 1'b1;
        tick();
        a_req_ready = 1'b0;
        check_output("sb_req_dropped", 64'(a_req_valid), 64'h0);
        check_output("sb_wait_no_done", 64'(a_done), 64'h0);
        a_rsp_valid = 1'b1;
        tick();
        a_rsp_valid = 1'b0;
        check_output("sb_done", 64'(a_done), 64'h1);
        check_output("sb_fault", 64'(a_fault), 64'h0);
        check_output("sb_cause", 64'(a_cause), 64'h0);
        tick();
        check_output("sb_done_pulse", 64'(a_done), 64'h0);
        check_output("sb_idle_ready", 64'(a_op_ready), 64'h1);

        // LH 0x2002 at minimum latency
        a_req_ready = 1'b1;
        apply_op32(1'b0, 3'b001, 32'h0000_2002, 32'h0);
        tick();
        check_output("lh_req_valid", 64'(a_req_valid), 64'h1);
        check_output("lh_req_addr", 64'(a_req_addr), 64'h2000);
        check_output("lh_req_strb", 64'(a_req_strb), 64'hF);
        check_output("lh_req_we", 64'(a_req_we), 64'h0);
        tick();
        check_output("lh_wait_no_done", 64'(a_done), 64'h0);
        a_rsp_valid = 1'b1; a_rsp_data = 32'h8001_0000;
        tick();
        a_rsp_valid = 1'b0;
        check_output("lh_done", 64'(a_done), 64'h1);
        check_output("lh_load_data", 64'(a_load_data), 64'hFFFF_8001);
        tick();
        check_output("lh_load_hold", 64'(a_load_data), 64'hFFFF_8001);

        apply_run32(1'b0, 3'b101, 32'h0000_2002, 32'h8001_0000, 1'b0);
        check_output("lhu_done", 64'(a_done), 64'h1);
        check_output("lhu_load_data", 64'(a_load_data), 64'h0000_8001);
        tick();

        // LW 0x1001 is misaligned and must not reach the bus
        apply_op32(1'b0, 3'b010, 32'h0000_1001, 32'h0);
        check_output("mis_no_req_check", 64'(a_req_valid), 64'h0);
        tick();
        check_output("mis_no_req_done", 64'(a_req_valid), 64'h0);
        check_output("mis_done", 64'(a_done), 64'h1);
        check_output("mis_fault", 64'(a_fault), 64'h1);
        check_output("mis_cause", 64'(a_cause), 64'h1);
        tick();
        check_output("mis_done_pulse", 64'(a_done), 64'h0);
        check_output("mis_fault_clear", 64'(a_fault), 64'h0);

        // funct3 111 at a misaligned address: illegal outranks misaligned
        apply_op32(1'b0, 3'b111, 32'h0000_1001, 32'h0);
        tick();
        check_output("ill_prio_cause", 64'(a_cause), 64'h4);
        check_output("ill_prio_done", 64'(a_done), 64'h1);
        tick();
        apply_op32(1'b0, 3'b011, 32'h0000_0008, 32'h0);
        tick();
        check_output("ld32_cause", 64'(a_cause), 64'h4);
        check_output("ld32_no_req", 64'(a_req_valid), 64'h0);
        tick();
        apply_op32(1'b1, 3'b100, 32'h0000_0010, 32'h55);
        tick();
        check_output("sbu_cause", 64'(a_cause), 64'h4);
        tick();

        apply_run32(1'b0, 3'b010, 32'h0000_3000, 32'h1234_5678, 1'b1);
        check_output("berr_done", 64'(a_done), 64'h1);
        check_output("berr_fault", 64'(a_fault), 64'h1);
        check_output("berr_cause", 64'(a_cause), 64'h2);
        check_output("berr_load_kept", 64'(a_load_data), 64'h0000_8001);
        tick();

        // TIMEOUT=4: WAIT lasts four cycles, then DONE with cause 3
        apply_op32(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        repeat (5) tick();
        check_output("to_not_yet", 64'(a_done), 64'h0);
        check_output("to_still_busy", 64'(a_op_ready), 64'h0);
        tick();
        check_output("to_done", 64'(a_done), 64'h1);
        check_output("to_cause", 64'(a_cause), 64'h3);
        a_rsp_valid = 1'b1; a_rsp_data = 32'hDEAD_BEEF;
        tick();
        check_output("late_no_done", 64'(a_done), 64'h0);
        check_output("late_load_kept", 64'(a_load_data), 64'h0000_8001);
        tick();
        a_rsp_valid = 1'b0;
        check_output("late_no_done2", 64'(a_done), 64'h0);
        check_output("late_idle", 64'(a_op_ready), 64'h1);

        // Response in the very cycle the counter expires beats the timeout
        apply_op32(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        repeat (5) tick();
        a_rsp_valid = 1'b1; a_rsp_data = 32'h8765_4321;
        tick();
        a_rsp_valid = 1'b0;
        check_output("race_done", 64'(a_done), 64'h1);
        check_output("race_cause", 64'(a_cause), 64'h0);
        check_output("race_load", 64'(a_load_data), 64'h8765_4321);
        tick();

        // 64-bit instance
        b_req_ready = 1'b1;
        apply_op64(1'b0, 3'b011, 32'h0000_0008, 64'h0);
        tick();
        check_output("ld64_req_addr", 64'(b_req_addr), 64'h8);
        check_output("ld64_req_strb", 64'(b_req_strb), 64'hFF);
        tick();
        b_rsp_valid = 1'b1; b_rsp_data = 64'hFEDC_BA98_7654_3210;
        tick();
        b_rsp_valid = 1'b0;
        check_output("ld64_done", 64'(b_done), 64'h1);
        check_output("ld64_cause", 64'(b_cause), 64'h0);
        check_output("ld64_load", b_load_data, 64'hFEDC_BA98_7654_3210);
        tick();

        apply_op64(1'b1, 3'b010, 32'h0000_0004, 64'h1122_3344);
        tick();
        check_output("sw64_req_addr", 64'(b_req_addr), 64'h0);
        check_output("sw64_req_wdata", b_req_wdata, 64'h1122_3344_0000_0000);
        check_output("sw64_req_strb", 64'(b_req_strb), 64'hF0);
        tick();
        b_rsp_valid = 1'b1; b_rsp_data = 64'h0;
        tick();
        b_rsp_valid = 1'b0;
        check_output("sw64_done", 64'(b_done), 64'h1);
        check_output("sw64_load_kept", b_load_data, 64'hFEDC_BA98_7654_3210);
        tick();

        apply_run64(1'b0, 3'b010, 32'h0000_000C, 64'h89AB_CDEF_0000_0000);
        check_output("lw64_load", b_load_data, 64'hFFFF_FFFF_89AB_CDEF);
        tick();
        apply_run64(1'b0, 3'b110, 32'h0000_000C, 64'h89AB_CDEF_0000_0000);
        check_output("lwu64_load", b_load_data, 64'h0000_0000_89AB_CDEF);
        tick();

        // Asynchronous reset while waiting for a response
        a_req_ready = 1'b0;
        apply_op32(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        tick();
        check_output("rstmid_req_addr", 64'(a_req_addr), 64'h5000);
        a_req_ready = 1'b1;
        tick();
        a_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("rstmid_op_ready", 64'(a_op_ready), 64'h1);
        check_output("rstmid_done", 64'(a_done), 64'h0);
        check_output("rstmid_req_valid", 64'(a_req_valid), 64'h0);
        check_output("rstmid_req_addr0", 64'(a_req_addr), 64'h0);
        check_output("rstmid_req_strb", 64'(a_req_strb), 64'h0);
        check_output("rstmid_load_data", 64'(a_load_data), 64'h0);
        a_rsp_valid = 1'b1; a_rsp_data = 32'h1111_1111;
        tick();
        check_output("rstmid_no_done", 64'(a_done), 64'h0);
        rst_n = 1'b1;
        tick();
        tick();
        a_rsp_valid = 1'b0;
        check_output("rstmid_after_done", 64'(a_done), 64'h0);
        check_output("rstmid_after_load", 64'(a_load_data), 64'h0);
        check_output("rstmid_after_ready", 64'(a_op_ready), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
